// File: rtl/fnd_scan_scheduler.sv
// Four-digit multiplexed 7-segment scan scheduler with dead-time, leading-zero
// blanking and tear-free, frame-aligned commit of newly loaded display values.
module fnd_scan_scheduler #(
  parameter int SCAN_DIV = 50_000,
  parameter int DEAD     = 500
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_load,
  input  logic [15:0] i_data,
  input  logic [3:0]  i_dp,
  input  logic        i_lzb,
  output logic [7:0]  o_seg,
  output logic [3:0]  o_com,
  output logic        o_ack
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEAD,
    S_DRIVE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    digit, digit_nx;
  logic          wrap;
  logic          commit;

  logic [15:0]   disp_data, pend_data;
  logic [3:0]    disp_dp, pend_dp;
  logic          pend_flag;

  logic [15:0]   upper;
  logic          blank;
  logic [7:0]    seg_nx;
  logic [3:0]    com_nx;

  function automatic logic [6:0] decode(input logic [3:0] nib);
    case (nib)
      4'd0:    decode = 7'h40;
      4'd1:    decode = 7'h79;
      4'd2:    decode = 7'h24;
      4'd3:    decode = 7'h30;
      4'd4:    decode = 7'h19;
      4'd5:    decode = 7'h12;
      4'd6:    decode = 7'h02;
      4'd7:    decode = 7'h78;
      4'd8:    decode = 7'h00;
      4'd9:    decode = 7'h10;
      default: decode = 7'h7F;
    endcase
  endfunction

  // Loss of enable overrides every other transition, so it is tested first.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_nx = state;
    cnt_nx   = cnt;
    digit_nx = digit;
    wrap     = 1'b0;
    if (!i_enable) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
      digit_nx = 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nx = S_DEAD;
          cnt_nx   = '0;
          digit_nx = 2'd0;
        end
        S_DEAD: begin
          cnt_nx = cnt + 1'b1;
          if (cnt == DEAD_LAST) state_nx = S_DRIVE;
        end
        S_DRIVE: begin
          if (cnt == SLOT_LAST) begin
            state_nx = S_DEAD;
            cnt_nx   = '0;
            digit_nx = digit + 2'd1;
            wrap     = (digit == 2'd3);
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Pending data reaches the display only between frames, or straight away when idle.
  assign commit = pend_flag && ((state == S_IDLE) || wrap);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      digit <= 2'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state <= state_nx;
      cnt   <= cnt_nx;
      digit <= digit_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      disp_data <= 16'h0000;
      disp_dp   <= 4'h0;
      pend_data <= 16'h0000;
      pend_dp   <= 4'h0;
      pend_flag <= 1'b0;
    end else begin
      if (commit) begin
        disp_data <= pend_data;
        disp_dp   <= pend_dp;
      end
      // A load in the commit cycle queues behind the value being committed.
      if (i_load) begin
        pend_data <= i_data;
        pend_dp   <= i_dp;
        pend_flag <= 1'b1;
      end else if (commit) begin
        pend_flag <= 1'b0;
      end
    end
  end

  // A digit is blank when it and every more significant nibble are zero.
  assign upper = disp_data >> {digit, 2'b00};
  assign blank = i_lzb && (digit != 2'd0) && (upper == 16'h0000);

  always_comb begin
    seg_nx = 8'hFF;
    com_nx = 4'hF;
    if (i_enable && (state == S_DRIVE)) begin
      com_nx      = ~(4'b0001 << digit);
      seg_nx[7]   = ~disp_dp[digit];
      seg_nx[6:0] = blank ? 7'h7F : decode(upper[3:0]);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_seg <= 8'hFF;
      o_com <= 4'hF;
      o_ack <= 1'b0;
    end else begin
      o_seg <= seg_nx;
      o_com <= com_nx;
      o_ack <= commit;
    end
  end

endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// Scoreboard bench for fnd_scan_scheduler: a phase-arithmetic reference model
// predicts each cycle's outputs; a monitor compares them on the falling edge.
module tb_fnd_scan_scheduler;

  localparam int SLOT  = 8;
  localparam int DEADC = 2;
  localparam int FRAME = 4 * SLOT;

  logic        i_clk = 1'b0;
  logic        i_reset_n;
  logic        i_enable;
  logic        i_load;
  logic [15:0] i_data;
  logic [3:0]  i_dp;
  logic        i_lzb;
  logic [7:0]  o_seg;
  logic [3:0]  o_com;
  logic        o_ack;

  fnd_scan_scheduler #(.SCAN_DIV(SLOT), .DEAD(DEADC)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_enable  (i_enable),
    .i_load    (i_load),
    .i_data    (i_data),
    .i_dp      (i_dp),
    .i_lzb     (i_lzb),
    .o_seg     (o_seg),
    .o_com     (o_com),
    .o_ack     (o_ack)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [7:0] seg;
    logic [3:0] com;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;

  // Reference model: scan position is just the number of cycles since enable.
  logic        m_run;
  int          m_phase;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pdp;
  logic        m_pv;

  logic        cur_en, cur_lzb;
  logic [15:0] cur_d;
  logic [3:0]  cur_dp;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] seg_code(input logic [3:0] n);
    logic [6:0] t;
    case (n)
      4'd0: t = 7'h40;  4'd1: t = 7'h79;  4'd2: t = 7'h24;  4'd3: t = 7'h30;
      4'd4: t = 7'h19;  4'd5: t = 7'h12;  4'd6: t = 7'h02;  4'd7: t = 7'h78;
      4'd8: t = 7'h00;  4'd9: t = 7'h10;
      default: t = 7'h7F;
    endcase
    return t;
  endfunction

  task automatic model_reset();
    m_run = 1'b0; m_phase = 0;
    m_disp = '0; m_dp = '0; m_pend = '0; m_pdp = '0; m_pv = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic ld, input logic [15:0] d,
                            input logic [3:0] dp, input logic lzb, output exp_t e);
    int          pos, dg;
    logic        wrap, commit;
    logic [15:0] upper;
    pos   = m_phase % SLOT;
    dg    = (m_phase / SLOT) % 4;
    e.seg = 8'hFF;
    e.com = 4'hF;
    if (en && m_run && pos >= DEADC) begin
      e.com      = 4'hF & ~(4'b0001 << dg);
      upper      = m_disp >> (4 * dg);
      e.seg[7]   = ~m_dp[dg];
      e.seg[6:0] = (lzb && dg != 0 && upper == 16'h0) ? 7'h7F : seg_code(upper[3:0]);
    end
    wrap   = en && m_run && (m_phase % FRAME) == FRAME - 1;
    commit = m_pv && (!m_run || wrap);
    e.ack  = commit;
    if (commit) begin
      m_disp = m_pend;
      m_dp   = m_pdp;
    end
    if (ld) begin
      m_pend = d; m_pdp = dp; m_pv = 1'b1;
    end else if (commit) begin
      m_pv = 1'b0;
    end
    if (!en) begin
      m_run = 1'b0; m_phase = 0;
    end else if (!m_run) begin
      m_run = 1'b1; m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic step(input logic en, input logic ld, input logic [15:0] d,
                      input logic [3:0] dp, input logic lzb);
    exp_t e;
    i_enable = en; i_load = ld; i_data = d; i_dp = dp; i_lzb = lzb;
    cur_en = en; cur_d = d; cur_dp = dp; cur_lzb = lzb;
    model_step(en, ld, d, dp, lzb, e);
    @(posedge i_clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) step(cur_en, 1'b0, cur_d, cur_dp, cur_lzb);
  endtask

  task automatic load(input logic [15:0] d, input logic [3:0] dp);
    step(cur_en, 1'b1, d, dp, cur_lzb);
  endtask

  task automatic run_to(input int ph);
    for (int i = 0; i < 4 * FRAME && !(m_run && (m_phase % FRAME) == ph); i++)
      step(1'b1, 1'b0, cur_d, cur_dp, cur_lzb);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    #1 i_reset_n = 1'b0;
    i_load = 1'b0;
    #1;
    check("reset_seg", 16'(o_seg), 16'h00FF);
    check("reset_com", 16'(o_com), 16'h000F);
    check("reset_ack", 16'(o_ack), 16'h0000);
    model_reset();
    @(negedge i_clk);
    #1 i_reset_n = 1'b1;
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("seg", 16'(o_seg), 16'(e.seg));
      check("com", 16'(o_com), 16'(e.com));
      check("ack", 16'(o_ack), 16'(e.ack));
    end
  end

  initial begin
    i_reset_n = 1'b1; i_enable = 1'b0; i_load = 1'b0;
    i_data = '0; i_dp = '0; i_lzb = 1'b0;
    cur_en = 1'b0; cur_d = '0; cur_dp = '0; cur_lzb = 1'b0;
    model_reset();
    #2 i_reset_n = 1'b0;
    do_reset();

    // Basic scan: load while idle, then enable.
    step(1'b0, 1'b1, 16'h1234, 4'h0, 1'b0);
    hold(2);
    step(1'b1, 1'b0, 16'h1234, 4'h0, 1'b0);
    hold(70);

    // Leading-zero blanking with dp on a blanked digit.
    step(1'b1, 1'b1, 16'h0070, 4'b0100, 1'b1);
    hold(80);

    // Tear-free commit: load while digit 1 is driven.
    step(1'b1, 1'b0, cur_d, cur_dp, 1'b0);
    run_to(SLOT + 3);
    load(16'h5555, 4'h0);
    hold(60);

    // Overwrite within one frame.
    run_to(1);
    load(16'h1111, 4'h0);
    hold(3);
    load(16'h2222, 4'h0);
    hold(70);

    // Load coinciding with the frame-boundary commit.
    run_to(5);
    load(16'h9876, 4'h1);
    run_to(FRAME - 1);
    load(16'h4321, 4'h8);
    hold(70);

    // Disable during DRIVE, then re-enable.
    run_to(SLOT + 5);
    step(1'b0, 1'b0, cur_d, cur_dp, cur_lzb);
    hold(3);
    step(1'b1, 1'b0, cur_d, cur_dp, cur_lzb);
    hold(40);

    // Reset mid-slot with a value pending.
    run_to(20);
    load(16'h8888, 4'hF);
    hold(1);
    do_reset();
    step(1'b1, 1'b0, cur_d, cur_dp, cur_lzb);
    hold(40);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic        en, ld, lzb;
      logic [15:0] d;
      if ($urandom_range(0, 399) == 0) do_reset();
      en  = cur_en ? ($urandom_range(0, 149) != 0) : ($urandom_range(0, 9) == 0);
      lzb = ($urandom_range(0, 49) == 0) ? ~cur_lzb : cur_lzb;
      ld  = ($urandom_range(0, 24) == 0);
      for (int k = 0; k < 4; k++)
        d[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      step(en, ld, ld ? d : cur_d, ld ? 4'($urandom_range(0, 15)) : cur_dp, lzb);
    end

    @(negedge i_clk);
    #1;
    check("queue_drained", 16'(exp_q.size()), 16'h0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fnd_scan_scheduler.md
FND_SCAN_SCHEDULER -- requirements
Module: fnd_scan_scheduler

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 50_000, giving the clock cycles per digit slot; legal range 4..2^20.
REQ-002 The block SHALL have parameter DEAD, default 500, giving the dead-time cycles at the start of each slot; legal range 1..SCAN_DIV-2.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single system clock, with all logic on its rising edge.
REQ-004 The block SHALL have port i_reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port i_enable, input, 1 bit: when high, display scanning runs.
REQ-006 The block SHALL have port i_load, input, 1 bit: request to capture a new value, sampled each cycle.
REQ-007 The block SHALL have port i_data, input, 16 bits: four BCD nibbles, with [3:0] as digit 0 (rightmost).
REQ-008 The block SHALL have port i_dp, input, 4 bits: decimal-point request per digit, captured together with i_data.
REQ-009 The block SHALL have port i_lzb, input, 1 bit: leading-zero blanking enable, sampled live.
REQ-010 The block SHALL have port o_seg, output, 8 bits, active-low: [7]=dp and [6:0]=g..a.
REQ-011 The block SHALL have port o_com, output, 4 bits, active-low: digit commons, with [0] as digit 0.
REQ-012 The block SHALL have port o_ack, output, 1 bit: a one-cycle pulse when a pending value becomes the displayed value.

Function
REQ-013 The block SHALL implement a state machine with states IDLE, DEAD and DRIVE.
- IDLE -> DEAD when i_enable=1.
- DEAD -> DRIVE when the slot counter reaches DEAD-1.
- DRIVE -> DEAD when the slot counter reaches SCAN_DIV-1; the digit index advances at the same time.
- Any state -> IDLE when i_enable=0 (checked first, every cycle).
REQ-014 The slot counter SHALL count 0..SCAN_DIV-1 and wrap to 0; it SHALL be held at 0 in IDLE.
REQ-015 The digit index SHALL be 2 bits, advance 0->1->2->3->0, and be held at 0 in IDLE.
REQ-016 On entry from IDLE, scanning SHALL start at digit 0 in DEAD with the slot counter at 0.
REQ-017 In IDLE and DEAD, o_com SHALL be 4'b1111 and o_seg SHALL be 8'hFF.
REQ-018 In DRIVE, exactly one o_com bit, the bit of the current digit, SHALL be 0.
REQ-019 o_seg and o_com SHALL be registered outputs, changing one cycle after the state or digit-index change that causes them.
REQ-020 Decode (active-low gfedcba) SHALL be: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex); nibble values 10..15 SHALL give 7F (all off).
REQ-021 o_seg[7] SHALL be the inverse of the displayed dp bit.
REQ-022 When i_lzb=1, digit k (k=3,2,1) SHALL be blanked (segments 7F) when its nibble and every higher nibble are 0; digit 0 is never blanked; dp is still shown on a blanked digit.
REQ-023 When i_load=1, i_data/i_dp SHALL be captured into a pending register and the pending flag set.
REQ-024 A later i_load before commit SHALL overwrite the pending value; only one o_ack SHALL result.
REQ-025 In a running scan, pending data SHALL commit to the display register only on the cycle the digit index wraps 3->0 (frame boundary), so no frame mixes old and new data.
REQ-026 o_ack SHALL pulse in the cycle after commit.
REQ-027 If i_load coincides with the frame-boundary commit cycle, the existing pending value SHALL commit and the new value SHALL become pending for the next frame.
REQ-028 In IDLE, a pending value SHALL commit on the cycle after capture, with o_ack one cycle later.
REQ-029 i_enable falling mid-slot SHALL blank outputs on the next cycle and keep the display register and pending state unchanged.

Reset
REQ-030 Asserting i_reset_n=0 SHALL asynchronously force the following, with no o_ack pulse on reset release:
- state IDLE, slot counter 0, digit index 0;
- display and pending registers 0, pending flag 0;
- o_seg=8'hFF, o_com=4'b1111, o_ack=0.
REQ-031 Reset asserted mid-frame SHALL discard any pending value.

Verification (SCAN_DIV=8, DEAD=2)
REQ-032 Basic scan: reset, load 16'h1234 with i_enable=0, then raise i_enable -> o_ack 2 cycles after load; each 8-cycle slot gives 2 blank cycles, then o_com=1110 with o_seg=8'h99 (4) for 6 cycles, then 1101/B0, 1011/A4, 0111/F9, then repeat.
REQ-033 Leading-zero blanking: display 16'h0070 with i_lzb=1 and i_dp=4'b0100 -> digit 3 o_seg=FF, digit 2 o_seg=7F (blank, dp on), digit 1 F8, digit 0 C0.
REQ-034 Tear-free commit: load 16'h5555 while digit 1 is driven -> digits 1..3 still show the old value; o_ack occurs 1 cycle after the 3->0 wrap; digit 0 of the new frame shows 92.
REQ-035 Overwrite: load 16'h1111, then 16'h2222 in the same frame -> single o_ack; the next frame shows 2222.
REQ-036 Disable and reset: drop i_enable during DRIVE -> outputs FF/1111 the next cycle; re-enable restarts at digit 0 DEAD; asserting i_reset_n mid-slot -> immediate FF/1111, no o_ack.
